// File: rtl/class_pkg.sv
// Shared definitions for the traffic classifier and other switch-level blocks:
// class-field extraction, occupancy threshold compares and default sizing.
package class_pkg;

  localparam int DEF_DATA_SIZE  = 10;
  localparam int DEF_FIFO_DEPTH = 8;

  // Class field is the top class_bits of a data_size-wide word (word is zero-extended).
  function automatic int class_of(input logic [63:0] word, input int data_size,
                                  input int class_bits);
    return int'(word >> (data_size - class_bits)) & ((32'sd1 << class_bits) - 1);
  endfunction

  function automatic logic at_or_above(input int count, input int thresh);
    return count >= thresh;
  endfunction

  function automatic logic at_or_below(input int count, input int thresh);
    return count <= thresh;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered 1-cycle read, occupancy flags and sticky error.
// A push to a full FIFO is accepted only alongside a successful pop; rejected ops set error.
module fifo_sync
  import class_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 dout_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 pop_ok;
  logic                 push_ok;

  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = at_or_above(int'(count), AF_THRESH);
  assign almost_empty = at_or_below(int'(count), AE_THRESH);

  // Pop never falls through: it needs an entry present before this cycle's push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      dout_valid <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      error <= error | (push && !push_ok) | (pop && !pop_ok);
    end
  end

endmodule

// File: rtl/class_nch.sv
// N-way classifier: steers each valid word by its top class bits into a per-class FIFO.
// Read data is registered (1 cycle after pop); fifo_pause is advisory, overflow drops and flags.
module class_nch
  import class_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int NUM_CLASS  = 4,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_SIZE-1:0]           in,
  input  logic                           in_valid,
  input  logic [NUM_CLASS-1:0]           pop,
  output logic [NUM_CLASS*DATA_SIZE-1:0] out,
  output logic [NUM_CLASS-1:0]           out_valid,
  output logic [NUM_CLASS-1:0]           fifo_full,
  output logic [NUM_CLASS-1:0]           fifo_empty,
  output logic [NUM_CLASS-1:0]           almost_full,
  output logic [NUM_CLASS-1:0]           almost_empty,
  output logic [NUM_CLASS-1:0]           fifo_pause,
  output logic [NUM_CLASS-1:0]           fifo_error,
  output logic                           Error
);

  localparam int CLASS_BITS = $clog2(NUM_CLASS);

  logic [CLASS_BITS-1:0] cls;
  logic [NUM_CLASS-1:0]  push;

  assign cls = CLASS_BITS'(class_of(64'(in), DATA_SIZE, CLASS_BITS));

  always_comb begin
    push = '0;
    if (in_valid) begin
      push[cls] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CLASS; i++) begin : g_fifo
    fifo_sync #(
      .DATA_SIZE  (DATA_SIZE),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AF_THRESH  (AF_THRESH),
      .AE_THRESH  (AE_THRESH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push[i]),
      .pop          (pop[i]),
      .din          (in),
      .dout         (out[i*DATA_SIZE +: DATA_SIZE]),
      .dout_valid   (out_valid[i]),
      .full         (fifo_full[i]),
      .empty        (fifo_empty[i]),
      .almost_full  (almost_full[i]),
      .almost_empty (almost_empty[i]),
      .error        (fifo_error[i])
    );
  end

  assign fifo_pause = almost_full;
  assign Error      = |fifo_error;

endmodule

// File: tb/tb_class_nch.sv
// Self-checking bench for class_nch: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_class_nch;

  localparam int DW = 10;
  localparam int NC = 4;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  in;
  logic           in_valid;
  logic [NC-1:0]  pop;
  logic [NC*DW-1:0] out;
  logic [NC-1:0]  out_valid, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [NC-1:0]  fifo_pause, fifo_error;
  logic           Error;

  int checks = 0;
  int errors = 0;

  class_nch #(.DATA_SIZE(DW), .NUM_CLASS(NC), .FIFO_DEPTH(DEPTH),
              .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .pop(pop),
    .out(out), .out_valid(out_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_pause(fifo_pause),
    .fifo_error(fifo_error), .Error(Error)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per class plus last-read data and sticky errors.
  logic [DW-1:0] q [NC][$];
  logic [DW-1:0] m_out [NC];
  logic [NC-1:0] m_ov;
  logic [NC-1:0] m_err;

  function automatic logic [NC-1:0] exp_full();
    for (int i = 0; i < NC; i++) exp_full[i] = (q[i].size() == DEPTH);
  endfunction
  function automatic logic [NC-1:0] exp_empty();
    for (int i = 0; i < NC; i++) exp_empty[i] = (q[i].size() == 0);
  endfunction
  function automatic logic [NC-1:0] exp_af();
    for (int i = 0; i < NC; i++) exp_af[i] = (q[i].size() >= AF);
  endfunction
  function automatic logic [NC-1:0] exp_ae();
    for (int i = 0; i < NC; i++) exp_ae[i] = (q[i].size() <= AE);
  endfunction

  // Drive one cycle from the negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input logic rst, input logic iv, input logic [DW-1:0] d,
                      input logic [NC-1:0] p);
    int c;
    logic pop_ok;
    reset = rst; in_valid = iv; in = d; pop = p;
    @(posedge clk);
    c = d / (1 << (DW - 2));
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        q[i].delete();
        m_out[i] = '0;
        m_ov[i] = 1'b0;
        m_err[i] = 1'b0;
      end else begin
        pop_ok = p[i] && (q[i].size() > 0);
        m_ov[i] = pop_ok;
        if (p[i] && !pop_ok) m_err[i] = 1'b1;
        if (pop_ok) m_out[i] = q[i].pop_front();
        if (iv && c == i) begin
          if (q[i].size() < DEPTH) q[i].push_back(d);
          else m_err[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; pop = '0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, '0);
    checks++;
    if (fifo_empty !== 4'hF || almost_empty !== 4'hF || fifo_full !== 4'h0 ||
        almost_full !== 4'h0 || fifo_pause !== 4'h0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b ae=%b full=%b af=%b pause=%b, want 1111 1111 0000 0000 0000",
               fifo_empty, almost_empty, fifo_full, almost_full, fifo_pause);
    end
    checks++;
    if (out !== '0 || out_valid !== 4'h0 || fifo_error !== 4'h0 || Error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out=%h ov=%b err=%b Error=%b, want all zero",
               out, out_valid, fifo_error, Error);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp [NC];
    exp[0] = 10'h0FF; exp[1] = 10'h1DD; exp[2] = 10'h2EE; exp[3] = 10'h3CC;
    for (int i = 0; i < NC; i++) step(1'b0, 1'b1, exp[i], '0);
    step(1'b0, 1'b0, '0, 4'hF);
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (out[i*DW +: DW] !== exp[i]) begin
        errors++;
        $display("FAIL basic_out%0d: got %h want %h", i, out[i*DW +: DW], exp[i]);
      end
    end
    checks++;
    if (out_valid !== 4'hF || fifo_empty !== 4'hF || Error !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: ov=%b empty=%b Error=%b want 1111 1111 0",
               out_valid, fifo_empty, Error);
    end
  endtask

  task automatic test_almost();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 10'(k), '0);
    checks++;
    if (almost_full[0] !== 1'b1 || fifo_pause[0] !== 1'b1 || almost_empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL almost_flags: af=%b pause=%b ae=%b want 1 1 0",
               almost_full[0], fifo_pause[0], almost_empty[0]);
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, '0, 4'b0001);
      checks++;
      if (out_valid[0] !== 1'b1 || out[0 +: DW] !== 10'(k)) begin
        errors++;
        $display("FAIL almost_pop%0d: ov=%b data=%h want 1 %h", k, out_valid[0], out[0 +: DW], 10'(k));
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b1, 10'h300 + 10'(k), '0);
      if (k == 7) begin
        checks++;
        if (fifo_full[3] !== 1'b1 || fifo_error[3] !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full: full=%b err=%b want 1 0", fifo_full[3], fifo_error[3]);
        end
      end
    end
    checks++;
    if (fifo_error[3] !== 1'b1 || Error !== 1'b1) begin
      errors++;
      $display("FAIL ovf_error: err=%b Error=%b want 1 1", fifo_error[3], Error);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, '0, 4'b1000);
    checks++;
    if (out[3*DW +: DW] !== 10'h307 || fifo_empty[3] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: last=%h empty=%b want 307 1", out[3*DW +: DW], fifo_empty[3]);
    end
  endtask

  task automatic test_simul();
    step(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 10'h100 + 10'(k), '0);
    step(1'b0, 1'b1, 10'h1AA, 4'b0010);
    checks++;
    if (out[DW +: DW] !== 10'h100 || out_valid[1] !== 1'b1 || fifo_full[1] !== 1'b1 ||
        fifo_error[1] !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: out=%h ov=%b full=%b err=%b want 100 1 1 0",
               out[DW +: DW], out_valid[1], fifo_full[1], fifo_error[1]);
    end
    step(1'b0, 1'b1, 10'h2BB, 4'b0100);
    checks++;
    if (fifo_error[2] !== 1'b1 || out_valid[2] !== 1'b0 || fifo_empty[2] !== 1'b0 ||
        almost_empty[2] !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty: err=%b ov=%b empty=%b ae=%b want 1 0 0 1",
               fifo_error[2], out_valid[2], fifo_empty[2], almost_empty[2]);
    end
    step(1'b0, 1'b0, '0, 4'b0100);
    checks++;
    if (out[2*DW +: DW] !== 10'h2BB || out_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL simul_readback: out=%h ov=%b want 2bb 1", out[2*DW +: DW], out_valid[2]);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 10'h0A0 + 10'(k), '0);
      step(1'b0, 1'b0, '0, 4'b0001);
      checks++;
      if (out[0 +: DW] !== 10'h0A0 + 10'(k) || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL wrap%0d: data=%h ov=%b want %h 1", k, out[0 +: DW], out_valid[0],
                 10'h0A0 + 10'(k));
      end
    end
    checks++;
    if (fifo_error[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_error: err=%b want 0", fifo_error[0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 10'h150 + 10'(k), '0);
    step(1'b0, 1'b0, '0, 4'b0100);
    step(1'b1, 1'b1, 10'h155, 4'b0010);
    checks++;
    if (fifo_empty[1] !== 1'b1 || out_valid !== 4'h0 || fifo_error !== 4'h0 || Error !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: empty1=%b ov=%b err=%b Error=%b want 1 0000 0000 0",
               fifo_empty[1], out_valid, fifo_error, Error);
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] p;
    for (int n = 0; n < 400; n++) begin
      p = '0;
      for (int i = 0; i < NC; i++) p[i] = ($urandom_range(99) < 40);
      step(1'b0, ($urandom_range(99) < 70), 10'($urandom), p);
      checks++;
      if (out_valid !== m_ov || fifo_error !== m_err || Error !== (|m_err)) begin
        errors++;
        $display("FAIL rand_ctl@%0d: ov=%b err=%b Error=%b want %b %b %b",
                 n, out_valid, fifo_error, Error, m_ov, m_err, |m_err);
      end
      checks++;
      if (fifo_full !== exp_full() || fifo_empty !== exp_empty() || almost_full !== exp_af() ||
          almost_empty !== exp_ae() || fifo_pause !== exp_af()) begin
        errors++;
        $display("FAIL rand_flags@%0d: f=%b e=%b af=%b ae=%b p=%b want %b %b %b %b %b", n,
                 fifo_full, fifo_empty, almost_full, almost_empty, fifo_pause,
                 exp_full(), exp_empty(), exp_af(), exp_ae(), exp_af());
      end
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (out[i*DW +: DW] !== m_out[i]) begin
          errors++;
          $display("FAIL rand_data@%0d cls%0d: got %h want %h", n, i, out[i*DW +: DW], m_out[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in = '0; pop = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_almost();
    test_overflow();
    test_simul();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/class_nch.md
Name: class_nch

Overview:
- Parametrised N-way traffic classifier for the PCIe switching datapath.
- Each accepted input word is steered by its top CLASS_BITS into one of NUM_CLASS per-class synchronous FIFOs.
- Each FIFO has independent pop, status flags, upstream pause and sticky error.
- Generalises the fixed 2-class/10-bit classifier: class count, width, depth and thresholds are parameters; adds input valid, registered out_valid and a global error.

Parameters:
- DATA_SIZE, 10, word width; class field is in[DATA_SIZE-1 -: CLASS_BITS].
- NUM_CLASS, 4, number of classes/FIFOs; power of 2, >=2.
- CLASS_BITS, $clog2(NUM_CLASS), derived localparam.
- FIFO_DEPTH, 8, entries per FIFO; power of 2.
- AF_THRESH, FIFO_DEPTH-2, almost_full/pause when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty when count <= AE_THRESH.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- in  in  DATA_SIZE  input word.
- in_valid  in  1  in is valid this cycle.
- pop  in  NUM_CLASS  per-class read request.
- out  out  NUM_CLASS*DATA_SIZE  per-class read data; class i at [i*DATA_SIZE +: DATA_SIZE].
- out_valid  out  NUM_CLASS  registered; out slice i is valid this cycle.
- fifo_full  out  NUM_CLASS  count == FIFO_DEPTH.
- fifo_empty  out  NUM_CLASS  count == 0.
- almost_full  out  NUM_CLASS  count >= AF_THRESH.
- almost_empty  out  NUM_CLASS  count <= AE_THRESH; includes empty.
- fifo_pause  out  NUM_CLASS  equals almost_full; upstream must stop sending that class.
- fifo_error  out  NUM_CLASS  sticky overflow/underflow flag.
- Error  out  1  OR-reduction of fifo_error.

Behaviour:
- Reset (synchronous, high on a posedge):
  - All pointers and counts go to 0; out = 0; out_valid = 0; fifo_error = 0.
  - Flags settle to empty=1, almost_empty=1, full=almost_full=pause=0, Error=0.
  - A reset mid-operation discards all FIFO contents; any push or pop in that cycle is ignored.
- Classification: cls = in[DATA_SIZE-1 -: CLASS_BITS]. The whole DATA_SIZE word, class field included, is stored.
- Push: when in_valid=1, write to FIFO[cls] if !fifo_full[cls], or if pop[cls] is accepted in the same cycle.
  - Otherwise the word is dropped and fifo_error[cls] is set.
  - in_valid=0 has no effect.
- Pop on class i, when pop[i] and !fifo_empty[i]:
  - out slice i <= head entry and out_valid[i] <= 1 on the next posedge (1-cycle read latency).
  - Otherwise out_valid[i] <= 0 and out slice i holds its last value.
  - pop[i] on empty sets fifo_error[i]. There is no fall-through, even with a simultaneous push to class i.
- Simultaneous events:
  - Push+pop to a full FIFO: both succeed, count unchanged.
  - Push+pop to an empty FIFO: push accepted, pop rejected with error, count -> 1.
  - Pushes and pops to different classes in one cycle are fully independent.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits, incremented or decremented per accepted op.
- All status flags decode combinationally from the registered count, so they reflect an operation one cycle after its posedge.
- fifo_error clears only on reset. Error tracks fifo_error combinationally.
- Pause is advisory: an upstream push to a paused but not full class is still accepted.

Decomposition:
- Shared package class_pkg holds:
  - the class-field extraction function (msb slice by CLASS_BITS);
  - count-to-flag threshold compare helpers;
  - default DATA_SIZE/FIFO_DEPTH constants shared with switch-level blocks.
- One sub-module, fifo_sync:
  - Parameters DATA_SIZE, FIFO_DEPTH, AF_THRESH, AE_THRESH.
  - Ports: clk, reset, push, pop, din, dout, dout_valid, full, empty, almost_full, almost_empty, error.
  - Instantiated NUM_CLASS times via generate.
- Top level contains only the class decoder, push demux and output flattening.

Test Plan (defaults: NUM_CLASS=4, DATA_SIZE=10, DEPTH=8, AF=6, AE=2):
1. Reset, then push 0x0FF, 0x1DD, 0x2EE, 0x3CC, then pop=4'b1111 -> next cycle out slices 0..3 = 0x0FF/0x1DD/0x2EE/0x3CC, out_valid=4'b1111, all empty=1, Error=0.
2. Push 6 words 0x000..0x005 to class 0 -> after 6th push almost_full[0]=pause[0]=1, almost_empty[0]=0. Pop 6 -> data returns 0x000..0x005 in order.
3. Push 9 words to class 3 (0x300..0x308) -> full[3]=1 after the 8th; 0x308 dropped, fifo_error[3]=1, Error=1. Drain 8 -> last out = 0x307.
4. Class 1 full, same-cycle push 0x1AA and pop[1] -> out = oldest entry, count stays 8, no error. Pop on empty class 2 with simultaneous push 0x2BB -> fifo_error[2]=1, out_valid[2]=0, count[2]=1.
5. Wrap-around: push/pop class 0 alternately 20 times with 0x0A0+k -> data in order across pointer wrap, no error.
6. Reset asserted with 3 entries in class 1 and pop[1]=1 -> next cycle empty[1]=1, out_valid=0, fifo_error=0, Error=0.
